ms_merge_arbiter: RTL and testbench

Round-robin scheduler that shares a single 32-element merge engine (two sorted 16-element halves in, one merged 32-element vector out) among NUM_REQ requesters. It accepts one 32-element job at a time over a valid/ready handshake, launches the engine, waits for its completion pulse, and returns the merged vector tagged with the requester index. It sits between the per-lane block producers of the merge-sort pipeline and the final merge level, and adds a completion watchdog.

---
 rtl/ms_merge_arbiter.sv | 135 +++++++++++++
 tb/tb_ms_merge_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_merge_arbiter.sv
// Round-robin front end for a shared 32-element merge engine: grants one job at a time,
// launches the engine, and returns the merged vector tagged with the owning requester.
module ms_merge_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 40,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*32*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [32*DATA_WIDTH-1:0]        res_data,
  output logic [ID_W-1:0]                 res_id,
  output logic [32*DATA_WIDTH-1:0]        m_idata,
  output logic                            m_ivalid,
  input  logic [32*DATA_WIDTH-1:0]        m_odata,
  input  logic                            m_ovalid,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int JOB_W = 32 * DATA_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   last_grant_reg;
  logic [ID_W-1:0]   id_reg;
  logic [WD_W-1:0]   wd_cnt_reg;
  logic [JOB_W-1:0]  job_reg;

  logic [JOB_W-1:0]  slice [NUM_REQ];
  logic [JOB_W-1:0]  sel_data;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   winner_hi;
  logic [ID_W-1:0]   winner_lo;
  logic              found_hi;
  logic              any_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign slice[gi]     = req_data[gi*JOB_W +: JOB_W];
      assign req_ready[gi] = (state_reg == S_IDLE) && any_valid && (winner == ID_W'(gi));
    end
  endgenerate

  assign any_valid = |req_valid;

  // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    found_hi  = 1'b0;
    winner_hi = '0;
    winner_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant_reg)) begin
          found_hi  = 1'b1;
          winner_hi = ID_W'(i);
        end else begin
          winner_lo = ID_W'(i);
        end
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_data = slice[i];
    end
  end

  assign m_idata = job_reg;
  assign busy    = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      wd_cnt_reg     <= '0;
      job_reg        <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_id         <= '0;
      m_ivalid       <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      m_ivalid    <= 1'b0;
      err_timeout <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (any_valid) begin
            job_reg        <= sel_data;
            id_reg         <= winner;
            last_grant_reg <= winner;
            m_ivalid       <= 1'b1;
            state_reg      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt_reg <= '0;
          state_reg  <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
          // A completion on the final watchdog cycle still counts as success.
          if (m_ovalid) begin
            res_data  <= m_odata;
            res_id    <= id_reg;
            res_valid <= 1'b1;
            state_reg <= S_HOLD;
          end else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_merge_arbiter.sv
// Directed bench for ms_merge_arbiter with a behavioural merge engine whose latency can be
// stretched or disabled to exercise the watchdog paths.
module tb_ms_merge_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int TO  = 34;
  localparam int IDW = 2;
  localparam int JW  = 32 * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*JW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [JW-1:0]     res_data;
  logic [IDW-1:0]    res_id;
  logic [JW-1:0]     m_idata;
  logic              m_ivalid;
  logic [JW-1:0]     m_odata;
  logic              m_ovalid;
  logic              busy;
  logic              err_timeout;

  logic              eng_en = 1'b1;
  int                eng_delay = 32;
  logic              late_pulse = 1'b0;
  logic              eng_ovalid;
  logic              eng_run;
  int                eng_cnt;
  logic [JW-1:0]     eng_job;

  int checks = 0;
  int errors = 0;
  logic err_seen;

  always #5 clk = ~clk;

  ms_merge_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .m_idata(m_idata), .m_ivalid(m_ivalid), .m_odata(m_odata), .m_ovalid(m_ovalid),
    .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [JW-1:0] merge_model(input logic [JW-1:0] j);
    logic [JW-1:0] o;
    logic [7:0] a, b;
    int ia, ib;
    o = '0; ia = 0; ib = 0;
    for (int k = 0; k < 32; k++) begin
      a = (ia < 16) ? j[ia*8 +: 8] : 8'h00;
      b = (ib < 16) ? j[(16+ib)*8 +: 8] : 8'h00;
      if (ib >= 16 || (ia < 16 && a >= b)) begin
        o[k*8 +: 8] = a; ia++;
      end else begin
        o[k*8 +: 8] = b; ib++;
      end
    end
    return o;
  endfunction

  function automatic logic [JW-1:0] make_job(input int s);
    logic [JW-1:0] j;
    for (int k = 0; k < 16; k++) begin
      j[k*8 +: 8]      = 8'(200 - 3*k - s);
      j[(16+k)*8 +: 8] = 8'(201 - 5*k - 2*s);
    end
    return j;
  endfunction

  // Engine: starts on m_ivalid, pulses result eng_delay edges later, data valid only then.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_run <= 1'b0; eng_cnt <= 0; eng_ovalid <= 1'b0; m_odata <= '0; eng_job <= '0;
    end else begin
      eng_ovalid <= 1'b0;
      m_odata    <= '0;
      if (eng_run) begin
        if (eng_cnt == eng_delay) begin
          eng_ovalid <= 1'b1;
          m_odata    <= merge_model(eng_job);
          eng_run    <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end else if (m_ivalid && eng_en) begin
        eng_run <= 1'b1;
        eng_cnt <= 1;
        eng_job <= m_idata;
      end
    end
  end

  assign m_ovalid = eng_ovalid | late_pulse;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [JW-1:0] obs, input logic [JW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      step; n++;
      if (err_timeout) err_seen = 1'b1;
    end
  endtask

  logic [JW-1:0] jobs [NR];
  logic [JW-1:0] ja, exp1;
  int order [5] = '{3, 0, 1, 2, 3};
  int n, gap;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0; err_seen = 1'b0;
    repeat (3) step;
    chk_i("rst_busy",      int'(busy), 0);
    chk_i("rst_req_ready", int'(req_ready), 0);
    chk_i("rst_res_valid", int'(res_valid), 0);
    chk_i("rst_m_ivalid",  int'(m_ivalid), 0);
    chk_i("rst_err",       int'(err_timeout), 0);
    chk_i("rst_res_id",    int'(res_id), 0);
    chk_d("rst_res_data",  res_data, '0);
    chk_d("rst_m_idata",   m_idata, '0);
    rst_n = 1'b1;
    step;

    // Single job on requester 2: A = 16..1, B = 32..17 merge to 32..1.
    for (int k = 0; k < 16; k++) begin
      ja[k*8 +: 8]      = 8'(16 - k);
      ja[(16+k)*8 +: 8] = 8'(32 - k);
    end
    for (int k = 0; k < 32; k++) exp1[k*8 +: 8] = 8'(32 - k);
    req_data[2*JW +: JW] = ja;
    req_valid = 4'b0100; #1;
    chk_i("single_grant", int'(req_ready), 4);
    step; req_valid = '0;
    chk_i("single_ready_drop", int'(req_ready), 0);
    chk_i("single_ivalid", int'(m_ivalid), 1);
    chk_i("single_busy", int'(busy), 1);
    chk_d("single_idata", m_idata, ja);
    wait_res(n);
    chk_i("single_latency", n, 34);
    chk_i("single_id", int'(res_id), 2);
    chk_d("single_data", res_data, exp1);
    res_ready = 1'b1;
    step;
    chk_i("single_res_drop", int'(res_valid), 0);
    chk_i("single_busy_low", int'(busy), 0);

    // Round-robin with all requesters held valid; last grant was 2.
    for (int r = 0; r < NR; r++) begin
      jobs[r] = make_job(r + 1);
      req_data[r*JW +: JW] = jobs[r];
    end
    req_valid = 4'b1111; #1;
    gap = 0;
    for (int g = 0; g < 5; g++) begin
      chk_i("rr_grant", int'(req_ready), 1 << order[g]);
      if (g > 0) chk_i("rr_spacing", gap, 36);
      step; gap = 1;
      chk_d("rr_idata", m_idata, jobs[order[g]]);
      wait_res(n); gap += n;
      chk_i("rr_id", int'(res_id), order[g]);
      chk_d("rr_data", res_data, merge_model(jobs[order[g]]));
      step; gap++;
      if (g == 4) req_valid = '0;
    end

    // Backpressure: result held 50 cycles while requester 1 waits.
    res_ready = 1'b0;
    req_valid = 4'b0011; #1;
    chk_i("bp_grant", int'(req_ready), 1);
    step; req_valid = 4'b0010;
    wait_res(n);
    chk_i("bp_latency", n, 34);
    for (int c = 0; c < 50; c++) begin
      step;
      chk_i("bp_valid", int'(res_valid), 1);
      chk_i("bp_id", int'(res_id), 0);
      chk_d("bp_data", res_data, merge_model(jobs[0]));
      chk_i("bp_req_ready", int'(req_ready), 0);
      chk_i("bp_ivalid", int'(m_ivalid), 0);
    end
    res_ready = 1'b1;
    step;
    chk_i("bp_release_valid", int'(res_valid), 0);
    chk_i("bp_next_grant", int'(req_ready), 2);
    step; req_valid = '0;
    wait_res(n);
    chk_i("bp_next_id", int'(res_id), 1);
    chk_d("bp_next_data", res_data, merge_model(jobs[1]));
    step;

    // Watchdog: engine ignores job 2; requester 3 pending behind it.
    eng_en = 1'b0;
    req_valid = 4'b1100; #1;
    chk_i("wd_grant", int'(req_ready), 4);
    step; req_valid = 4'b1000;
    n = 0;
    while (!err_timeout && n < 80) begin step; n++; end
    chk_i("wd_latency", n, 35);
    chk_i("wd_res_valid", int'(res_valid), 0);
    chk_i("wd_busy", int'(busy), 0);
    chk_i("wd_next_grant", int'(req_ready), 8);
    late_pulse = 1'b1; eng_en = 1'b1;
    step;
    late_pulse = 1'b0; req_valid = '0;
    chk_i("wd_late_ignored", int'(res_valid), 0);
    chk_i("wd_single_pulse", int'(err_timeout), 0);
    chk_i("wd_next_ivalid", int'(m_ivalid), 1);
    wait_res(n);
    chk_i("wd_next_latency", n, 34);
    chk_i("wd_next_id", int'(res_id), 3);
    chk_d("wd_next_data", res_data, merge_model(jobs[3]));
    step;

    // Edge race: completion lands exactly on wd_cnt == TIMEOUT-1.
    eng_delay = 33; err_seen = 1'b0;
    req_valid = 4'b0001; #1;
    chk_i("race_grant", int'(req_ready), 1);
    step; req_valid = '0;
    wait_res(n);
    chk_i("race_latency", n, 35);
    chk_i("race_no_err", int'(err_seen), 0);
    chk_i("race_id", int'(res_id), 0);
    chk_d("race_data", res_data, merge_model(jobs[0]));
    step;
    chk_i("race_err_after", int'(err_timeout), 0);
    eng_delay = 32;

    // Reset during WAIT, then grant order restarts at requester 0.
    req_valid = 4'b0010; #1;
    chk_i("mrst_grant", int'(req_ready), 2);
    step; req_valid = '0;
    repeat (16) step;
    chk_i("mrst_busy_before", int'(busy), 1);
    rst_n = 1'b0; #1;
    chk_i("mrst_busy", int'(busy), 0);
    chk_i("mrst_res_valid", int'(res_valid), 0);
    chk_i("mrst_m_ivalid", int'(m_ivalid), 0);
    chk_i("mrst_err", int'(err_timeout), 0);
    chk_i("mrst_res_id", int'(res_id), 0);
    chk_d("mrst_m_idata", m_idata, '0);
    chk_d("mrst_res_data", res_data, '0);
    repeat (3) step;
    rst_n = 1'b1;
    step;
    req_valid = 4'b0101; #1;
    chk_i("mrst_resume_grant", int'(req_ready), 1);
    step; req_valid = '0;
    wait_res(n);
    chk_i("mrst_latency", n, 34);
    chk_i("mrst_id", int'(res_id), 0);
    chk_d("mrst_data", res_data, merge_model(jobs[0]));
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
